sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: N-bank asynchronous SRAM controller with wait states and per-byte write selects.
// Optional build macro SRAM_RMW_EN: partial writes run as read-modify-write and ram_be_n is tied low.
module sram_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned BANKS       = 2,
   parameter int unsigned BANK_LSB    = 22,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ce_i,
   input  logic                      we_i,
   input  logic [DATA_W/8-1:0]       sel_i,
   input  logic [31:0]               addr_i,
   input  logic [DATA_W-1:0]         data_i,
   output logic                      ready_o,
   output logic [DATA_W-1:0]         data_o,
   inout  wire  [BANKS*DATA_W-1:0]   ram_data,
   output logic [BANKS*ADDR_W-1:0]   ram_addr,
   output logic [BANKS-1:0]          ram_ce_n,
   output logic [BANKS-1:0]          ram_oe_n,
   output logic [BANKS-1:0]          ram_we_n,
   output logic [BANKS*DATA_W/8-1:0] ram_be_n
);
   localparam int unsigned NB     = DATA_W / 8;
   localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

   typedef enum logic [2:0] {IDLE, RD, MERGE, WSETUP, WPULSE, WHOLD, DONE} state_t;

   state_t            state, nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [BANK_W-1:0] bank_q, bank_in, bank_sel;
   logic [ADDR_W-1:0] word_in;
   logic [NB-1:0]     sel_q;
   logic [DATA_W-1:0] wdata_q, rd_word;
   logic              rmw_in, rmw_q;
   logic [BANKS-1:0]  hit, drv_q, drv_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;
   logic              unused_addr;

   assign bank_in     = (BANKS > 1) ? addr_i[BANK_LSB +: BANK_W] : '0;
   assign word_in     = addr_i[ADDR_W+1:2];
   assign unused_addr = ^addr_i;
   assign bank_sel    = (state == IDLE) ? bank_in : bank_q;
   assign rd_word     = ram_data[bank_q*DATA_W +: DATA_W];

`ifdef SRAM_RMW_EN
   logic [DATA_W-1:0] merged;

   assign rmw_in   = we_i && (sel_i != '1);
   assign ram_be_n = '0;

   always_comb begin
      merged = rd_word;
      for (int unsigned i = 0; i < NB; i++)
         if (sel_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
   end
`else
   logic [NB-1:0]       sel_nxt;
   logic [BANKS*NB-1:0] be_n_nxt;

   assign rmw_in  = 1'b0;
   assign sel_nxt = (state == IDLE) ? sel_i : sel_q;

   // byte enables cover the whole driven window so they never change under a live we_n edge
   always_comb begin
      be_n_nxt = '1;
      for (int unsigned b = 0; b < BANKS; b++) begin
         if (bank_sel == BANK_W'(b) && nxt == RD)
            be_n_nxt[b*NB +: NB] = '0;
         else if (bank_sel == BANK_W'(b) && (nxt == WSETUP || nxt == WPULSE || nxt == WHOLD))
            be_n_nxt[b*NB +: NB] = ~sel_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ram_be_n <= '1;
      else     ram_be_n <= be_n_nxt;
   end
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (ce_i) nxt = (we_i && !rmw_in) ? WSETUP : RD;
         RD:      if (cnt == '0) nxt = rmw_q ? MERGE : DONE;
         MERGE:   nxt = WSETUP;
         WSETUP:  nxt = WPULSE;
         WPULSE:  if (cnt == '0) nxt = WHOLD;
         WHOLD:   nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (!ce_i && state != IDLE && state != DONE) nxt = IDLE;

      if ((nxt == RD && state != RD) || (nxt == WPULSE && state != WPULSE))
         cnt_nxt = 4'(WAIT_CYCLES);
      else if (cnt != '0)
         cnt_nxt = cnt - 4'd1;
      else
         cnt_nxt = cnt;
   end

   // strobes are decoded from the next state so that every pin is a flop output
   always_comb begin
      hit      = '0;
      ce_n_nxt = '1;
      oe_n_nxt = '1;
      we_n_nxt = '1;
      drv_nxt  = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
         hit[b]      = (bank_sel == BANK_W'(b));
         ce_n_nxt[b] = !(hit[b] && nxt != IDLE && nxt != DONE);
         oe_n_nxt[b] = !(hit[b] && nxt == RD);
         we_n_nxt[b] = !(hit[b] && nxt == WPULSE);
         drv_nxt[b]  = hit[b] && (nxt == WSETUP || nxt == WPULSE || nxt == WHOLD);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ready_o  <= 1'b0;
         data_o   <= '0;
         ram_addr <= '0;
         ram_ce_n <= '1;
         ram_oe_n <= '1;
         ram_we_n <= '1;
         drv_q    <= '0;
      end else begin
         state    <= nxt;
         cnt      <= cnt_nxt;
         ready_o  <= (nxt == DONE);
         ram_ce_n <= ce_n_nxt;
         ram_oe_n <= oe_n_nxt;
         ram_we_n <= we_n_nxt;
         drv_q    <= drv_nxt;
         if (state == IDLE && ce_i) begin
            bank_q   <= bank_in;
            sel_q    <= sel_i;
            wdata_q  <= data_i;
            rmw_q    <= rmw_in;
            ram_addr <= {BANKS{word_in}};
         end
         if (state == RD && nxt == DONE) data_o <= rd_word;
`ifdef SRAM_RMW_EN
         // merge lands at the end of the read; MERGE itself is the bus turnaround cycle
         if (state == RD && nxt == MERGE) wdata_q <= merged;
`endif
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bus
      assign ram_data[b*DATA_W +: DATA_W] = drv_q[b] ? wdata_q : 'z;
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl against a two-bank behavioural SRAM model.
// Read data flows through a scoreboard queue; strobe activity is tallied by a negedge monitor.
`timescale 1ns/1ps
module tb_sram_ctrl;
   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst, ce_i, we_i;
   logic [3:0]  sel_i;
   logic [31:0] addr_i, data_i;
   logic        ready_o;
   logic [31:0] data_o;
   wire  [63:0] ram_data;
   logic [39:0] ram_addr;
   logic [1:0]  ram_ce_n, ram_oe_n, ram_we_n;
   logic [7:0]  ram_be_n;

   int          n_vec = 0, n_err = 0;
   logic [31:0] exp_q [$];
   logic [31:0] last_rd;

   logic [31:0] mem [0:1][0:255];
   logic        pl_en = 1'b0, pl_bank = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;

   int          we1_low = 0, we0_low = 0, oe0_low = 0, bank0_act = 0, rdy_cnt = 0;
   logic [19:0] we1_addr = '0;
   logic [3:0]  be0_pulse = '1, be1_pulse = '1;

   sram_ctrl #(
      .DATA_W(32), .ADDR_W(20), .BANKS(2), .BANK_LSB(22), .WAIT_CYCLES(W)
   ) dut (
      .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
      .data_i(data_i), .ready_o(ready_o), .data_o(data_o), .ram_data(ram_data),
      .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
      .ram_be_n(ram_be_n)
   );

   always #5 clk = ~clk;

   for (genvar b = 0; b < 2; b++) begin : g_sram
      assign ram_data[b*32 +: 32] = (!ram_ce_n[b] && !ram_oe_n[b] && ram_we_n[b])
                                    ? mem[b][ram_addr[b*20 +: 8]] : 'z;
   end

   always @(posedge clk) begin
      if (pl_en) mem[pl_bank][pl_idx] <= pl_val;
      for (int b = 0; b < 2; b++)
         if (!ram_ce_n[b] && !ram_we_n[b])
            for (int k = 0; k < 4; k++)
               if (!ram_be_n[b*4+k])
                  mem[b][ram_addr[b*20 +: 8]][k*8 +: 8] <= ram_data[b*32+k*8 +: 8];
   end

   always @(negedge clk) begin
      if (!ram_we_n[1]) begin we1_low++; we1_addr = ram_addr[39:20]; be1_pulse = ram_be_n[7:4]; end
      if (!ram_we_n[0]) begin we0_low++; be0_pulse = ram_be_n[3:0]; end
      if (!ram_oe_n[0]) oe0_low++;
`ifdef SRAM_RMW_EN
      if (!ram_ce_n[0] || !ram_oe_n[0] || !ram_we_n[0]) bank0_act++;
`else
      if (!ram_ce_n[0] || !ram_oe_n[0] || !ram_we_n[0] || ram_be_n[3:0] != 4'hF) bank0_act++;
`endif
      if (ready_o === 1'b1) rdy_cnt++;
   end

   task automatic preload(input logic b, input logic [7:0] idx, input logic [31:0] v);
      @(negedge clk);
      pl_en = 1'b1; pl_bank = b; pl_idx = idx; pl_val = v;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // one request, ce_i held until ready_o; lat = negedges after the accept edge, -1 on timeout
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, output int lat);
      @(negedge clk);
      ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = wd;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ready_o === 1'b1) begin lat = n; break; end
      end
      ce_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] exp_be;
`ifdef SRAM_RMW_EN
      exp_be = 8'h00;
`else
      exp_be = 8'hFF;
`endif
      repeat (3) @(negedge clk);
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
      n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data_o: got %h want 0", data_o); end
      n_vec++; if (ram_addr !== 40'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
      n_vec++; if (ram_ce_n !== 2'b11) begin n_err++; $display("FAIL reset_ce_n: got %b want 11", ram_ce_n); end
      n_vec++; if (ram_oe_n !== 2'b11) begin n_err++; $display("FAIL reset_oe_n: got %b want 11", ram_oe_n); end
      n_vec++; if (ram_we_n !== 2'b11) begin n_err++; $display("FAIL reset_we_n: got %b want 11", ram_we_n); end
      n_vec++; if (ram_be_n !== exp_be) begin n_err++; $display("FAIL reset_be_n: got %h want %h", ram_be_n, exp_be); end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      int n, lat;
      logic [31:0] bus_hi, exp;
      preload(1'b0, 8'd4, 32'hCAFEBABE);
      @(negedge clk);
      ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0040_0020; sel_i = 4'hF; data_i = 32'h1234_5678;
      n = 0;
      while (ram_we_n[1] !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      n_vec++; if (ram_we_n[1] !== 1'b0) begin n_err++; $display("FAIL mid_pulse_reached: we_n %b want 0", ram_we_n[1]); end
      rst = 1'b1; ce_i = 1'b0; we_i = 1'b0;
      @(negedge clk);
      bus_hi = ram_data[63:32];
      n_vec++; if (ram_we_n !== 2'b11) begin n_err++; $display("FAIL mid_rst_we_n: got %b want 11", ram_we_n); end
      n_vec++; if (ram_ce_n !== 2'b11) begin n_err++; $display("FAIL mid_rst_ce_n: got %b want 11", ram_ce_n); end
      n_vec++; if (bus_hi === 32'h1234_5678) begin n_err++; $display("FAIL mid_rst_bus: got %h want Z", bus_hi); end
      rst = 1'b0;
      exp_q.push_back(32'hCAFEBABE);
      issue(1'b0, 32'h0000_0010, 4'h0, 32'h0, lat);
      exp = exp_q.pop_front();
      n_vec++; if (lat != W + 2) begin n_err++; $display("FAIL rd_after_rst_lat: got %0d want %0d", lat, W + 2); end
      n_vec++; if (data_o !== exp) begin n_err++; $display("FAIL rd_after_rst_data: got %h want %h", data_o, exp); end
      last_rd = 32'hCAFEBABE;
   endtask

   task automatic test_write_bank1();
      int lat, s_we, s_b0;
      logic [31:0] bus_hi, exp;
      s_we = we1_low; s_b0 = bank0_act;
      issue(1'b1, 32'h0040_0008, 4'hF, 32'hDEADBEEF, lat);
      bus_hi = ram_data[63:32];
      n_vec++; if (lat != W + 4) begin n_err++; $display("FAIL wr_lat: got %0d want %0d", lat, W + 4); end
      n_vec++; if (we1_low - s_we != W + 1) begin n_err++; $display("FAIL wr_pulse_len: got %0d want %0d", we1_low - s_we, W + 1); end
      n_vec++; if (we1_addr !== 20'd2) begin n_err++; $display("FAIL wr_addr: got %h want 2", we1_addr); end
      n_vec++; if (be1_pulse !== 4'h0) begin n_err++; $display("FAIL wr_be_n: got %b want 0000", be1_pulse); end
      n_vec++; if (bus_hi === 32'hDEADBEEF) begin n_err++; $display("FAIL wr_bus_release: got %h want Z", bus_hi); end
      n_vec++; if (mem[1][2] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_mem: got %h want deadbeef", mem[1][2]); end
      exp_q.push_back(32'hDEADBEEF);
      issue(1'b0, 32'h0040_0008, 4'h0, 32'h0, lat);
      exp = exp_q.pop_front();
      n_vec++; if (lat != W + 2) begin n_err++; $display("FAIL rb_lat: got %0d want %0d", lat, W + 2); end
      n_vec++; if (data_o !== exp) begin n_err++; $display("FAIL rb_data: got %h want %h", data_o, exp); end
      n_vec++; if (bank0_act != s_b0) begin n_err++; $display("FAIL bank0_quiet: got %0d active cycles want 0", bank0_act - s_b0); end
      last_rd = 32'hDEADBEEF;
   endtask

   task automatic test_byte_sel();
      int lat, s_oe, s_we, exp_lat, exp_oe;
      logic [3:0] exp_be;
      logic [31:0] exp;
`ifdef SRAM_RMW_EN
      exp_lat = 2 * W + 6; exp_oe = W + 1; exp_be = 4'b0000;
`else
      exp_lat = W + 4; exp_oe = 0; exp_be = 4'b1010;
`endif
      preload(1'b0, 8'd3, 32'hAABBCCDD);
      s_oe = oe0_low; s_we = we0_low;
      issue(1'b1, 32'h0000_000C, 4'b0101, 32'h1122_3344, lat);
      n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL sel_lat: got %0d want %0d", lat, exp_lat); end
      n_vec++; if (oe0_low - s_oe != exp_oe) begin n_err++; $display("FAIL sel_read_phase: got %0d want %0d", oe0_low - s_oe, exp_oe); end
      n_vec++; if (we0_low - s_we != W + 1) begin n_err++; $display("FAIL sel_pulse_len: got %0d want %0d", we0_low - s_we, W + 1); end
      n_vec++; if (be0_pulse !== exp_be) begin n_err++; $display("FAIL sel_be_n: got %b want %b", be0_pulse, exp_be); end
      n_vec++; if (data_o !== last_rd) begin n_err++; $display("FAIL sel_data_o_kept: got %h want %h", data_o, last_rd); end
      n_vec++; if (mem[0][3] !== 32'hAA22CC44) begin n_err++; $display("FAIL sel_mem: got %h want aa22cc44", mem[0][3]); end
      exp_q.push_back(32'hAA22CC44);
      issue(1'b0, 32'h0000_000C, 4'h0, 32'h0, lat);
      exp = exp_q.pop_front();
      n_vec++; if (lat != W + 2) begin n_err++; $display("FAIL sel_rb_lat: got %0d want %0d", lat, W + 2); end
      n_vec++; if (data_o !== exp) begin n_err++; $display("FAIL sel_rb_data: got %h want %h", data_o, exp); end
      last_rd = 32'hAA22CC44;
   endtask

   task automatic test_abort();
      int lat, s_r;
      logic [31:0] exp;
      preload(1'b1, 8'd5, 32'h55AA55AA);
      s_r = rdy_cnt;
      @(negedge clk);
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0040_0014;
      repeat (2) @(negedge clk);
      ce_i = 1'b0;
      @(negedge clk);
      n_vec++; if (ram_ce_n !== 2'b11) begin n_err++; $display("FAIL abort_ce_n: got %b want 11", ram_ce_n); end
      n_vec++; if (ram_oe_n !== 2'b11) begin n_err++; $display("FAIL abort_oe_n: got %b want 11", ram_oe_n); end
      repeat (6) @(negedge clk);
      n_vec++; if (rdy_cnt != s_r) begin n_err++; $display("FAIL abort_no_ready: got %0d pulses want 0", rdy_cnt - s_r); end
      n_vec++; if (data_o !== last_rd) begin n_err++; $display("FAIL abort_data_o: got %h want %h", data_o, last_rd); end
      exp_q.push_back(32'h55AA55AA);
      issue(1'b0, 32'h0040_0014, 4'h0, 32'h0, lat);
      exp = exp_q.pop_front();
      n_vec++; if (lat != W + 2) begin n_err++; $display("FAIL abort_recover_lat: got %0d want %0d", lat, W + 2); end
      n_vec++; if (data_o !== exp) begin n_err++; $display("FAIL abort_recover_data: got %h want %h", data_o, exp); end
      last_rd = 32'h55AA55AA;
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      logic [31:0] exp;
      preload(1'b0, 8'd0, 32'h0101_0101);
      preload(1'b1, 8'd0, 32'h0202_0202);
      exp_q.push_back(32'h0101_0101);
      exp_q.push_back(32'h0202_0202);
      @(negedge clk);
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0000;
      t1 = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ready_o === 1'b1) begin t1 = n; break; end
      end
      exp = exp_q.pop_front();
      n_vec++; if (t1 != W + 2) begin n_err++; $display("FAIL b2b_first_lat: got %0d want %0d", t1, W + 2); end
      n_vec++; if (data_o !== exp) begin n_err++; $display("FAIL b2b_first_data: got %h want %h", data_o, exp); end
      addr_i = 32'h0040_0000;
      t2 = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ready_o === 1'b1) begin t2 = n; break; end
      end
      ce_i = 1'b0;
      exp = exp_q.pop_front();
      n_vec++; if (t2 != W + 3) begin n_err++; $display("FAIL b2b_gap: got %0d want %0d", t2, W + 3); end
      n_vec++; if (data_o !== exp) begin n_err++; $display("FAIL b2b_second_data: got %h want %h", data_o, exp); end
   endtask

   initial begin
      rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; sel_i = '0; addr_i = '0; data_i = '0; last_rd = '0;
      test_reset();
      test_reset_mid_write();
      test_write_bank1();
      test_byte_sel();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
